led_pattern_sequencer: RTL and testbench

- Downstream LED driver stage for the board's PCIe status LEDs.
- Replaces the fixed counter-bit blink with a loadable sequence of LED patterns: up to DEPTH steps, each with a PWM brightness.
- Patterns are written over a valid/ready config interface, then played back in a loop at a programmable step rate onto the LED pins.

---
 rtl/led_pattern_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// Plays a loadable table of LED on/off patterns, each with its own PWM duty, in a loop at a fixed step rate.
// Build option: define LED_ACTIVE_LOW_EN to drive the LED pins inverted (idle/reset value all-ones).
module led_pattern_sequencer #(
   parameter int unsigned NUM_LEDS = 3,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned STEP_DIV = 4194304,
   parameter int unsigned PWM_BITS = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   input  logic [NUM_LEDS-1:0]        cfg_pattern,
   input  logic [PWM_BITS-1:0]        cfg_duty,
   input  logic                       cfg_last,
   input  logic                       enable,
   output logic [NUM_LEDS-1:0]        LED,
   output logic                       busy,
   output logic [$clog2(DEPTH)-1:0]   step_idx
);

   localparam int unsigned IDX_W   = $clog2(DEPTH);
   localparam int unsigned LEN_W   = IDX_W + 1;
   localparam int unsigned DIV_W   = $clog2(STEP_DIV);
   localparam int unsigned PWM_TOP = (2 ** PWM_BITS) - 2;

`ifdef LED_ACTIVE_LOW_EN
   localparam logic [NUM_LEDS-1:0] LED_IDLE = '1;
`else
   localparam logic [NUM_LEDS-1:0] LED_IDLE = '0;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t               state_q,    state_d;
   logic                 loaded_q,   loaded_d;
   logic [IDX_W-1:0]     wr_ptr_q,   wr_ptr_d;
   logic [LEN_W-1:0]     length_q,   length_d;
   logic [DIV_W-1:0]     div_cnt_q,  div_cnt_d;
   logic [PWM_BITS-1:0]  pwm_cnt_q,  pwm_cnt_d;
   logic [IDX_W-1:0]     step_idx_q, step_idx_d;
   logic [NUM_LEDS-1:0]  led_q,      led_d;
   logic                 cfg_ready_q;
   logic                 busy_q;

   logic [NUM_LEDS-1:0]  pattern_q [DEPTH];
   logic [PWM_BITS-1:0]  duty_q    [DEPTH];

   logic                 xfer_c;
   logic                 wr_en_c;
   logic [IDX_W-1:0]     wr_idx_c;
   logic                 pwm_on_c;
   logic [NUM_LEDS-1:0]  led_raw_c;

   assign xfer_c    = cfg_valid & cfg_ready_q;
   assign pwm_on_c  = (pwm_cnt_q < duty_q[step_idx_q]);
   assign led_raw_c = pattern_q[step_idx_q] & {NUM_LEDS{pwm_on_c}};

   // Next-state: sequence loading, playback timing and LED drive value.
   always_comb begin
      state_d    = state_q;
      loaded_d   = loaded_q;
      wr_ptr_d   = wr_ptr_q;
      length_d   = length_q;
      div_cnt_d  = div_cnt_q;
      pwm_cnt_d  = pwm_cnt_q;
      step_idx_d = step_idx_q;
      led_d      = LED_IDLE;
      wr_en_c    = 1'b0;
      wr_idx_c   = '0;

      case (state_q)
         IDLE: begin
            if (xfer_c) begin
               // Any accepted entry here starts a fresh sequence at index 0.
               wr_en_c  = 1'b1;
               wr_idx_c = '0;
               if (cfg_last) begin
                  length_d = LEN_W'(1);
                  loaded_d = 1'b1;
               end else begin
                  loaded_d = 1'b0;
                  wr_ptr_d = IDX_W'(1);
                  state_d  = LOAD;
               end
            end else if (enable && loaded_q) begin
               state_d    = RUN;
               step_idx_d = '0;
               div_cnt_d  = '0;
               pwm_cnt_d  = '0;
            end
         end

         LOAD: begin
            if (xfer_c) begin
               wr_en_c  = 1'b1;
               wr_idx_c = wr_ptr_q;
               wr_ptr_d = wr_ptr_q + IDX_W'(1);
               if (cfg_last || (wr_ptr_q == IDX_W'(DEPTH - 1))) begin
                  length_d = LEN_W'(wr_ptr_q) + LEN_W'(1);
                  loaded_d = 1'b1;
                  state_d  = IDLE;
               end
            end
         end

         RUN: begin
            if (!enable) begin
               state_d = IDLE;
            end else begin
`ifdef LED_ACTIVE_LOW_EN
               led_d = ~led_raw_c;
`else
               led_d = led_raw_c;
`endif
               if (pwm_cnt_q == PWM_BITS'(PWM_TOP)) begin
                  pwm_cnt_d = '0;
               end else begin
                  pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
               end

               if (div_cnt_q == DIV_W'(STEP_DIV - 1)) begin
                  div_cnt_d = '0;
                  if ((LEN_W'(step_idx_q) + LEN_W'(1)) == length_q) begin
                     step_idx_d = '0;
                  end else begin
                     step_idx_d = step_idx_q + IDX_W'(1);
                  end
               end else begin
                  div_cnt_d = div_cnt_q + DIV_W'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         loaded_q    <= 1'b0;
         wr_ptr_q    <= '0;
         length_q    <= '0;
         div_cnt_q   <= '0;
         pwm_cnt_q   <= '0;
         step_idx_q  <= '0;
         led_q       <= LED_IDLE;
         cfg_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         loaded_q    <= loaded_d;
         wr_ptr_q    <= wr_ptr_d;
         length_q    <= length_d;
         div_cnt_q   <= div_cnt_d;
         pwm_cnt_q   <= pwm_cnt_d;
         step_idx_q  <= step_idx_d;
         led_q       <= led_d;
         cfg_ready_q <= (state_d != RUN);
         busy_q      <= (state_d == RUN);
      end
   end

   // Pattern table; contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (wr_en_c && !rst) begin
         pattern_q[wr_idx_c] <= cfg_pattern;
         duty_q[wr_idx_c]    <= cfg_duty;
      end
   end

   assign cfg_ready = cfg_ready_q;
   assign busy      = busy_q;
   assign step_idx  = step_idx_q;
   assign LED       = led_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: expected playback is queued from a table model, then popped per cycle.
module tb_led_pattern_sequencer;

   localparam int unsigned NL   = 3;
   localparam int unsigned DP   = 4;
   localparam int unsigned SD   = 4;
   localparam int unsigned PB   = 2;
   localparam int unsigned PPER = (2 ** PB) - 1;

   logic          clk;
   logic          rst;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [NL-1:0] cfg_pattern;
   logic [PB-1:0] cfg_duty;
   logic          cfg_last;
   logic          enable;
   logic [NL-1:0] LED;
   logic          busy;
   logic [1:0]    step_idx;

   led_pattern_sequencer #(
      .NUM_LEDS (NL),
      .DEPTH    (DP),
      .STEP_DIV (SD),
      .PWM_BITS (PB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_pattern (cfg_pattern),
      .cfg_duty    (cfg_duty),
      .cfg_last    (cfg_last),
      .enable      (enable),
      .LED         (LED),
      .busy        (busy),
      .step_idx    (step_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NL-1:0] led;
      logic          busy;
      logic [1:0]    step;
   } exp_t;

   exp_t exp_q [$];

   int n_checks = 0;
   int n_errors = 0;

   // Reference table model
   logic [NL-1:0] m_pat  [DP];
   logic [PB-1:0] m_duty [DP];
   int            m_len;
   int            m_wr;
   bit            m_in_load;

   function automatic logic [NL-1:0] pin(input logic [NL-1:0] v);
`ifdef LED_ACTIVE_LOW_EN
      return ~v;
`else
      return v;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Called at a negedge; returns at the following negedge with cfg_valid dropped.
   task automatic load_entry(input logic [NL-1:0] p, input logic [PB-1:0] d, input logic last);
      chk("cfg_ready_load", 32'(cfg_ready), 32'd1);
      cfg_valid   = 1'b1;
      cfg_pattern = p;
      cfg_duty    = d;
      cfg_last    = last;
      if (!m_in_load) begin
         m_pat[0]  = p;
         m_duty[0] = d;
         if (last) begin
            m_len = 1;
         end else begin
            m_wr      = 1;
            m_in_load = 1'b1;
         end
      end else begin
         m_pat[m_wr]  = p;
         m_duty[m_wr] = d;
         if (last || (m_wr == DP - 1)) begin
            m_len     = m_wr + 1;
            m_in_load = 1'b0;
         end
         m_wr++;
      end
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
   endtask

   // Queue n expected samples from the model, then enable playback and compare each cycle.
   task automatic play(input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.busy = 1'b1;
         e.step = 2'((k / SD) % m_len);
         if (k == 0) begin
            e.led = pin('0);
         end else begin
            int t;
            int st;
            t  = k - 1;
            st = (t / SD) % m_len;
            e.led = pin(((t % PPER) < int'(m_duty[st])) ? m_pat[st] : '0);
         end
         exp_q.push_back(e);
      end
      enable = 1'b1;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         chk("run_led",  32'(LED),      32'(e.led));
         chk("run_busy", 32'(busy),     32'(e.busy));
         chk("run_step", 32'(step_idx), 32'(e.step));
      end
   endtask

   task automatic stop_run();
      enable = 1'b0;
      @(negedge clk);
      chk("stop_led",   32'(LED),       32'(pin('0)));
      chk("stop_busy",  32'(busy),      32'd0);
      chk("stop_ready", 32'(cfg_ready), 32'd1);
   endtask

   task automatic idle_checks(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk({tag, "_busy"}, 32'(busy), 32'd0);
         chk({tag, "_led"},  32'(LED),  32'(pin('0)));
      end
   endtask

   initial begin
      rst         = 1'b1;
      cfg_valid   = 1'b0;
      cfg_pattern = '0;
      cfg_duty    = '0;
      cfg_last    = 1'b0;
      enable      = 1'b0;
      m_len       = 0;
      m_wr        = 0;
      m_in_load   = 1'b0;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_led",   32'(LED),       32'(pin('0)));
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd1);
      chk("rst_step",  32'(step_idx),  32'd0);
      rst    = 1'b0;
      enable = 1'b1;
      idle_checks("noload", 3);
      enable = 1'b0;
      @(negedge clk);

      // Three-step sequence with full brightness, including wrap
      load_entry(3'b001, 2'd3, 1'b0);
      load_entry(3'b010, 2'd3, 1'b0);
      load_entry(3'b100, 2'd3, 1'b1);
      play(14);
      stop_run();

      // PWM duty 1 then duty 0 on single-entry sequences
      load_entry(3'b111, 2'd1, 1'b1);
      play(9);
      stop_run();
      load_entry(3'b101, 2'd0, 1'b1);
      play(6);
      stop_run();

      // Auto-terminate at DEPTH entries
      load_entry(3'b001, 2'd3, 1'b0);
      load_entry(3'b010, 2'd2, 1'b0);
      load_entry(3'b100, 2'd3, 1'b0);
      load_entry(3'b011, 2'd1, 1'b0);
      chk("auto_len_model", 32'(m_len), 32'd4);
      play(20);
      stop_run();

      // Enable dropped during step 1, then restart from step 0
      play(6);
      stop_run();
      play(6);
      stop_run();

      // Config wins over enable in IDLE; LOAD ignores enable
      enable = 1'b1;
      load_entry(3'b010, 2'd3, 1'b0);
      chk("simul_busy", 32'(busy), 32'd0);
      idle_checks("load_en", 3);

      // Reset during LOAD: nothing loaded, enable ignored
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      m_in_load = 1'b0;
      m_len     = 0;
      idle_checks("post_rst", 4);
      chk("post_rst_step", 32'(step_idx), 32'd0);
      enable = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
